// File: rtl/fifo_pkg.sv
// Shared constants and parameter sanity checks for the synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Depth must be a power of two and at least 4 so the extra pointer MSB
  // cleanly separates full from empty.
  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  // Both thresholds must lie in 1..DEPTH-1 to give meaningful flags.
  function automatic bit thresholds_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth - 1) && (ae >= 1) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one write port, one registered read port.
// Only the read register is reset; the array keeps whatever it held.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Array write; deliberately no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read data only moves on an accepted read, otherwise it holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointer, occupancy flag and error-pulse logic around
// a fifo_mem storage block. Flags are derived straight from the registered
// pointers so they track the post-edge occupancy with no extra lag.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 wr_err,
  output logic                 rd_err,
  output logic [PTR_WIDTH:0]   count
);

  // Elaboration-time guards on the parameter set.
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_sync: DEPTH must be a power of two and >= 4");
  end
  if (PTR_WIDTH != $clog2(DEPTH)) begin : g_bad_ptr_width
    $error("fifo_sync: PTR_WIDTH must equal $clog2(DEPTH)");
  end
  if (!thresholds_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_thresholds
    $error("fifo_sync: AF_LEVEL/AE_LEVEL must be within 1..DEPTH-1");
  end

  localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] AF_CNT  = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_CNT  = (PTR_WIDTH+1)'(AE_LEVEL);

  // Pointers carry one extra wrap bit beyond the address.
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic               wr_err_q, wr_err_d;
  logic               rd_err_q, rd_err_d;
  logic               wr_acc, rd_acc;
  logic [PTR_WIDTH:0] occ;

  // Occupancy and flags come straight from the current pointers.
  always_comb begin
    occ   = wr_ptr_q - rd_ptr_q;
    full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
            (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
  end

  assign count        = occ;
  assign almost_full  = (occ >= AF_CNT);
  assign almost_empty = (occ <= AE_CNT);

  // Accept/reject decisions. When full, a concurrent read still goes
  // through and only the write is refused; the mirror holds when empty.
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_err_d = wr_en && full;
    rd_err_d = rd_en && empty;
  end

  // Next-state pointers: advance only on accepted transfers, wrapping
  // naturally through the extra MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer and error-pulse registers; reset empties the FIFO logically.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;

  // Storage. Reset is also gated into the enables so a same-cycle
  // request cannot touch memory while the FIFO is being cleared.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q[PTR_WIDTH-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_acc && !rst),
    .raddr_i (rd_ptr_q[PTR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: a queue models the FIFO contents, each
// accepted write pushes, each accepted read pops the expected rdata.
module tb_fifo_sync;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PW = 4;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic [W-1:0]  wdata, rdata;
  logic          full, empty, almost_full, almost_empty, wr_err, rd_err;
  logic [PW:0]   count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  sb_q [$];
  logic [W-1:0]  exp_rdata;
  logic          exp_wr_err, exp_rd_err;
  logic [W-1:0]  first_bytes [$];

  always #5 clk = ~clk;

  fifo_sync #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .wr_err(wr_err), .rd_err(rd_err), .count(count)
  );

  // Expected {full,empty,almost_full,almost_empty,wr_err,rd_err,count}.
  function automatic logic [10:0] model_status();
    int n;
    n = sb_q.size();
    return {n == D, n == 0, n >= AF, n <= AE, exp_wr_err, exp_rd_err, 5'(n)};
  endfunction

  // One clock of stimulus; updates the scoreboard from the pre-edge state.
  task automatic drive(input logic w, input logic [W-1:0] d, input logic r);
    bit fm, em;
    fm = (sb_q.size() == D);
    em = (sb_q.size() == 0);
    wr_en = w; wdata = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    exp_wr_err = w && fm;
    exp_rd_err = r && em;
    if (r && !em) exp_rdata = sb_q.pop_front();
    if (w && !fm) sb_q.push_back(d);
  endtask

  // Reset with both requests asserted: reset must win.
  task automatic apply_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sb_q.delete();
    exp_rdata = '0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({full, empty, almost_full, almost_empty, wr_err, rd_err, count} !== 11'b01010000000) begin
      errors++;
      $display("FAIL reset_flags got %b exp %b", {full, empty, almost_full, almost_empty, wr_err, rd_err, count}, 11'b01010000000);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 00", rdata);
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      checks++;
      if ({full, empty, almost_full, almost_empty, wr_err, rd_err, count} !== model_status()) begin
        errors++;
        $display("FAIL fill_status i=%0d got %b exp %b", i, {full, empty, almost_full, almost_empty, wr_err, rd_err, count}, model_status());
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got %b exp 1", full);
    end
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL drain_data i=%0d got %h exp %h", i, rdata, exp_rdata);
      end
      checks++;
      if ({full, empty, almost_full, almost_empty, wr_err, rd_err, count} !== model_status()) begin
        errors++;
        $display("FAIL drain_status i=%0d got %b exp %b", i, {full, empty, almost_full, almost_empty, wr_err, rd_err, count}, model_status());
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    first_bytes.delete();
    for (int i = 0; i < D + 1; i++) begin
      logic [W-1:0] b;
      b = 8'(8'h10 + i);
      if (i < D) first_bytes.push_back(b);
      drive(1'b1, b, 1'b0);
    end
    checks++;
    if ({wr_err, count, full} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL ovf_pulse got wr_err=%b count=%0d full=%b exp 1 16 1", wr_err, count, full);
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if ({wr_err, count} !== {1'b0, 5'd16}) begin
      errors++;
      $display("FAIL ovf_pulse_end got wr_err=%b count=%0d exp 0 16", wr_err, count);
    end
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (rdata !== first_bytes[i] || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL ovf_data i=%0d got %h exp %h", i, rdata, first_bytes[i]);
      end
    end
  endtask

  task automatic test_underflow();
    // Leaves FIFO empty with a known last rdata from the previous task.
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if ({rd_err, count, empty, rdata} !== {1'b1, 5'd0, 1'b1, exp_rdata}) begin
      errors++;
      $display("FAIL unf_pulse got rd_err=%b count=%0d empty=%b rdata=%h exp 1 0 1 %h", rd_err, count, empty, rdata, exp_rdata);
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if ({rd_err, rdata} !== {1'b0, exp_rdata}) begin
      errors++;
      $display("FAIL unf_pulse_end got rd_err=%b rdata=%h exp 0 %h", rd_err, rdata, exp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 11; i++) drive(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'($urandom), 1'b1);
      checks++;
      if (rdata !== exp_rdata || count !== 5'd11 || wr_err || rd_err) begin
        errors++;
        $display("FAIL b2b i=%0d got rdata=%h count=%0d err=%b%b exp %h 11 00", i, rdata, count, wr_err, rd_err, exp_rdata);
      end
    end
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL b2b_drain i=%0d got %h exp %h", i, rdata, exp_rdata);
      end
    end
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL b2b_empty got empty=%b count=%0d exp 1 0", empty, count);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    apply_reset();
    checks++;
    if ({count, empty, almost_empty, full, rdata} !== {5'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset got count=%0d empty=%b ae=%b full=%b rdata=%h exp 0 1 1 0 00", count, empty, almost_empty, full, rdata);
    end
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (rdata !== 8'hA5 || rdata !== exp_rdata || count !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_new got rdata=%h count=%0d exp a5 0", rdata, count);
    end
  endtask

  task automatic test_simul_edges();
    apply_reset();
    for (int i = 0; i < D; i++) drive(1'b1, 8'(8'h80 + i), 1'b0);
    drive(1'b1, 8'hFF, 1'b1);
    checks++;
    if ({count, wr_err, rd_err, rdata} !== {5'd15, 1'b1, 1'b0, 8'h80}) begin
      errors++;
      $display("FAIL simul_full got count=%0d wr_err=%b rd_err=%b rdata=%h exp 15 1 0 80", count, wr_err, rd_err, rdata);
    end
    while (sb_q.size() > 0) drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h3C, 1'b1);
    checks++;
    if ({count, rd_err, wr_err, rdata} !== {5'd1, 1'b1, 1'b0, exp_rdata}) begin
      errors++;
      $display("FAIL simul_empty got count=%0d rd_err=%b wr_err=%b rdata=%h exp 1 1 0 %h", count, rd_err, wr_err, rdata, exp_rdata);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (rdata !== 8'h3C || count !== 5'd0) begin
      errors++;
      $display("FAIL simul_empty_data got rdata=%h count=%0d exp 3c 0", rdata, count);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    exp_rdata = '0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    test_simul_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
